// File: rtl/div_share_pkg.sv
// Shared types and the round-robin helper for the divider-sharing arbiter.
package div_share_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_t;

  // rr_pick supports up to MaxReq requesters.
  localparam int unsigned MaxReq = 32;
  localparam int unsigned IdxW   = 5;

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } pick_t;

  // First set bit of req searching ptr+1, ptr+2, ... modulo n.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] req, input int ptr, input int n);
    pick_t res;
    res = '0;
    for (int j = 0; j < int'(MaxReq); j++) begin
      if (j < n && j > ptr && req[j] && !res.found) begin
        res.found = 1'b1;
        res.idx   = IdxW'(j);
      end
    end
    for (int j = 0; j < int'(MaxReq); j++) begin
      if (j < n && j <= ptr && req[j] && !res.found) begin
        res.found = 1'b1;
        res.idx   = IdxW'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/divu_int.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, done pulse
// WIDTH cycles after start (one cycle after start for a zero divisor).
module divu_int #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, den_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q, done_q, dbz_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_den, nxt_rem, nxt_quo;
  logic [WIDTH:0]   trial;
  logic             fits;

  // The start cycle already performs the first step from the live operands.
  always_comb begin
    src_rem = run_q ? rem_q : '0;
    src_quo = run_q ? quo_q : num;
    src_den = run_q ? den_q : den;
    trial   = {src_rem, src_quo[WIDTH-1]} - {1'b0, src_den};
    fits    = ~trial[WIDTH];
    nxt_rem = fits ? trial[WIDTH-1:0] : {src_rem[WIDTH-2:0], src_quo[WIDTH-1]};
    nxt_quo = {src_quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        rem_q <= nxt_rem;
        quo_q <= nxt_quo;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (start) begin
        if (den == '0) begin
          dbz_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          dbz_q <= 1'b0;
          rem_q <= nxt_rem;
          quo_q <= nxt_quo;
          den_q <= den;
          cnt_q <= CW'(WIDTH - 1);
          run_q <= 1'b1;
        end
      end
    end
  end

  assign done  = done_q;
  assign valid = done_q & ~dbz_q;
  assign dbz   = dbz_q;
  assign val   = quo_q;
  assign rem   = rem_q;

endmodule

// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one divu_int among N_REQ requesters; one
// division outstanding at a time, response returned on a one-hot valid.
module div_share_arb
  import div_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_num,
  input  logic [N_REQ*WIDTH-1:0] req_den,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_quo,
  output logic [WIDTH-1:0]       rsp_rem,
  output logic                   rsp_dbz,
  output logic                   busy
);

  localparam int unsigned PW = $clog2(N_REQ);

  state_t           state_q;
  logic [PW-1:0]    ptr_q, gnt_q;
  logic [WIDTH-1:0] num_q, den_q, quo_q, rem_q;
  logic             dbz_q;
  logic [N_REQ-1:0] rsp_valid_q;

  logic [MaxReq-1:0] req_ext;
  pick_t             pick;
  logic [WIDTH-1:0]  sel_num, sel_den;
  logic [N_REQ-1:0]  gnt_oh;

  logic             div_start, div_done, div_dbz;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             unused_div_valid;

  always_comb begin
    req_ext                = '0;
    req_ext[N_REQ-1:0]     = req_valid;
    pick                   = rr_pick(req_ext, int'(ptr_q), int'(N_REQ));
    sel_num                = '0;
    sel_den                = '0;
    req_ready              = '0;
    gnt_oh                 = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (pick.idx == IdxW'(k)) begin
        sel_num = req_num[k*WIDTH +: WIDTH];
        sel_den = req_den[k*WIDTH +: WIDTH];
      end
      // Gated by rst_n so no accept is advertised while held in reset.
      req_ready[k] = rst_n && (state_q == StIdle) && pick.found && (pick.idx == IdxW'(k));
      gnt_oh[k]    = (gnt_q == PW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= PW'(N_REQ - 1);
      gnt_q       <= '0;
      num_q       <= '0;
      den_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick.found) begin
            num_q   <= sel_num;
            den_q   <= sel_den;
            gnt_q   <= pick.idx[PW-1:0];
            state_q <= StLaunch;
          end
        end
        StLaunch: state_q <= StWait;
        StWait: begin
          if (div_done) begin
            if (div_dbz) begin
              quo_q <= '1;
              rem_q <= num_q;
              dbz_q <= 1'b1;
            end else begin
              quo_q <= div_quo;
              rem_q <= div_rem;
              dbz_q <= 1'b0;
            end
            rsp_valid_q <= gnt_oh;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (|(rsp_valid_q & rsp_ready)) begin
            rsp_valid_q <= '0;
            ptr_q       <= gnt_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign div_start = (state_q == StLaunch);

  divu_int #(
    .WIDTH(WIDTH)
  ) u_divu (
    .clk  (clk),
    .rst_n(rst_n),
    .start(div_start),
    .num  (num_q),
    .den  (den_q),
    .done (div_done),
    .valid(unused_div_valid),
    .dbz  (div_dbz),
    .val  (div_quo),
    .rem  (div_rem)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_quo   = quo_q;
  assign rsp_rem   = rem_q;
  assign rsp_dbz   = dbz_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_div_share_arb.sv
// Self-checking bench for div_share_arb: vector table, hand-written corner
// sequences and randomized contention against a round-robin/division model.
module tb_div_share_arb;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_num, req_den;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W-1:0]   rsp_quo, rsp_rem;
  logic           rsp_dbz, busy;

  logic [W-1:0] op_num [N];
  logic [W-1:0] op_den [N];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ptr_m = N - 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_num[k*W +: W] = op_num[k];
      req_den[k*W +: W] = op_den[k];
    end
  end

  div_share_arb #(
    .N_REQ(N),
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_num  (req_num),
    .req_den  (req_den),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_quo  (rsp_quo),
    .rsp_rem  (rsp_rem),
    .rsp_dbz  (rsp_dbz),
    .busy     (busy)
  );

  typedef struct {
    int         req;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_next(input int ptr, input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++) begin
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_quo(input logic [W-1:0] n, input logic [W-1:0] d);
    return (d == 0) ? {W{1'b1}} : W'(int'(n) / int'(d));
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] n, input logic [W-1:0] d);
    return (d == 0) ? n : W'(int'(n) % int'(d));
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (rsp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full transaction for requester g; mask_after replaces req_valid after
  // acceptance, hold cycles of backpressure are applied before the response handshake.
  task automatic serve(input int g, input logic [N-1:0] mask_after, input int hold,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                       input int elat);
    bit ok;
    int c0;
    wait_ready(ok);
    check("grant_seen", 32'(ok), 32'd1);
    if (!ok) return;
    check("grant_onehot", 32'(req_ready), 32'(1 << g));
    c0 = cyc;
    @(negedge clk);
    req_valid = mask_after;
    wait_rsp(ok);
    check("rsp_seen", 32'(ok), 32'd1);
    if (!ok) return;
    check("latency", 32'(cyc - c0), 32'(elat));
    check("rsp_valid", 32'(rsp_valid), 32'(1 << g));
    check("quo", 32'(rsp_quo), 32'(eq));
    check("rem", 32'(rsp_rem), 32'(er));
    check("dbz", 32'(rsp_dbz), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~(4'(1) << g);
      @(negedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'(1 << g));
      check("hold_quo", 32'(rsp_quo), 32'(eq));
      check("hold_rem", 32'(rsp_rem), 32'(er));
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_start", 32'(dut.div_start), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 4'(1) << g;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    ptr_m = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] masks [7];
    int           gord  [7];
    logic [N-1:0] mask;
    int           g, bad;
    bit           ok;

    vecs[0] = '{1, 16'd100,   16'd7,     16'd14,    16'd2,  1'b0, W + 2};
    vecs[1] = '{2, 16'd55,    16'd0,     16'hFFFF,  16'd55, 1'b1, 3};
    vecs[2] = '{0, 16'd65535, 16'd1,     16'd65535, 16'd0,  1'b0, W + 2};
    vecs[3] = '{3, 16'd5,     16'd9,     16'd0,     16'd5,  1'b0, W + 2};
    vecs[4] = '{1, 16'd0,     16'd5,     16'd0,     16'd0,  1'b0, W + 2};
    vecs[5] = '{2, 16'd65535, 16'd65535, 16'd1,     16'd0,  1'b0, W + 2};
    vecs[6] = '{0, 16'd0,     16'd0,     16'hFFFF,  16'd0,  1'b1, 3};

    for (int k = 0; k < N; k++) begin
      op_num[k] = W'(1000 + 37 * k);
      op_den[k] = W'(k + 3);
    end

    // Reset values, with every requester already asking.
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_quo", 32'(rsp_quo), 32'd0);
    check("rst_rem", 32'(rsp_rem), 32'd0);
    check("rst_dbz", 32'(rsp_dbz), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all valid gives 0,1,2,3,0; then only 0 and 3 alternate.
    masks = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h9, 4'h9, 4'h9};
    gord  = '{0, 1, 2, 3, 0, 3, 0};
    for (int s = 0; s < 7; s++) begin
      g = gord[s];
      serve(g, (s < 6) ? masks[s + 1] : 4'h0, 0, ref_quo(op_num[g], op_den[g]),
            ref_rem(op_num[g], op_den[g]), 1'b0, W + 2);
    end

    // Vector table: single requesters, edge operands, divide by zero.
    for (int v = 0; v < 7; v++) begin
      op_num[vecs[v].req] = vecs[v].num;
      op_den[vecs[v].req] = vecs[v].den;
      req_valid = 4'(1) << vecs[v].req;
      serve(vecs[v].req, 4'h0, 0, vecs[v].quo, vecs[v].rem, vecs[v].dbz, vecs[v].lat);
    end

    // Backpressure for 10 cycles while requester 0 waits.
    op_num[3] = 16'd1234;
    op_den[3] = 16'd10;
    op_num[0] = 16'd77;
    op_den[0] = 16'd8;
    req_valid = 4'h8;
    serve(3, 4'h1, 10, 16'd123, 16'd4, 1'b0, W + 2);
    serve(0, 4'h0, 0, 16'd9, 16'd5, 1'b0, W + 2);

    // Reset in the middle of WAIT discards the operation.
    op_num[1] = 16'd1000;
    op_den[1] = 16'd3;
    req_valid = 4'h2;
    wait_ready(ok);
    check("mid_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_quo", 32'(rsp_quo), 32'd0);
    check("mid_rst_rem", 32'(rsp_rem), 32'd0);
    check("mid_rst_dbz", 32'(rsp_dbz), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = N - 1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0 || busy) bad++;
    end
    check("mid_rst_quiet", 32'(bad), 32'd0);
    op_num[2] = 16'd9;
    op_den[2] = 16'd2;
    req_valid = 4'h4;
    serve(2, 4'h0, 0, 16'd4, 16'd1, 1'b0, W + 2);

    // Randomized contention against the round-robin and division model.
    for (int r = 0; r < 30; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        op_num[k] = W'($urandom);
        case ($urandom % 8)
          0:       op_den[k] = '0;
          1:       op_den[k] = 16'd1;
          2, 3:    op_den[k] = W'($urandom_range(2, 20));
          default: op_den[k] = W'($urandom);
        endcase
      end
      req_valid = mask;
      while (mask != '0) begin
        g = rr_next(ptr_m, mask);
        mask = mask & ~(4'(1) << g);
        serve(g, mask, int'($urandom % 3), ref_quo(op_num[g], op_den[g]),
              ref_rem(op_num[g], op_den[g]), (op_den[g] == 0),
              (op_den[g] == 0) ? 3 : W + 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_arb.md
# div_share_arb

Round-robin scheduler that shares one iterative unsigned divider (`divu_int`) among `N_REQ` requesters in the streaming-average datapath, for example per-channel sum/count averaging.
- Accepts one division request at a time through a valid/ready handshake.
- Launches the divider and waits for its completion pulse.
- Returns quotient, remainder and divide-by-zero status to the granted requester through a per-requester valid/ready response.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 16: operand and result width; must be a power of two and ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: one-hot accept; the request is accepted when `req_valid[g] & req_ready[g]`.
- `req_num` in N_REQ*WIDTH: dividends, requester k at `[k*WIDTH +: WIDTH]`.
- `req_den` in N_REQ*WIDTH: divisors, same packing.
- `rsp_valid` out N_REQ: one-hot response valid.
- `rsp_ready` in N_REQ: per-requester response ready.
- `rsp_quo` out WIDTH: quotient, shared bus.
- `rsp_rem` out WIDTH: remainder, shared bus.
- `rsp_dbz` out 1: divide by zero, shared bus.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, LAUNCH, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, the round-robin pick selects winner g.
  - `req_ready[g]` is driven combinationally in the same cycle; all other `req_ready` bits are 0.
  - On the clock edge, num/den of g are registered, g is stored, and the FSM goes to LAUNCH.
- **LAUNCH:** divider `start` = 1 for exactly this cycle, then the FSM goes to WAIT.
- **WAIT:** on the divider's `done`:
  - If divider `dbz` = 0: register `val`→`rsp_quo`, `rem`→`rsp_rem`, `rsp_dbz` = 0.
  - If divider `dbz` = 1: force `rsp_quo` = all ones, `rsp_rem` = registered num, `rsp_dbz` = 1.
  - The FSM goes to RESP.
- **RESP:**
  - `rsp_valid[g]` = 1, and the response data is held stable until `rsp_ready[g]`.
  - On the handshake edge: round-robin pointer ← g, FSM → IDLE.
- **Round-robin pick:** search order is ptr+1, ptr+2, … wrapping modulo N_REQ. ptr resets to N_REQ−1, so requester 0 wins first.
- **Rules for requesters:** `req_valid` and the operands must stay stable until accepted. `req_ready` is 0 in every state except IDLE, so only one division is ever outstanding.
- **Ignored inputs:**
  - `rsp_ready` of non-granted requesters has no effect.
  - A `req_valid` that drops in IDLE before being accepted has no effect.
- **Reset:** asserting `rst_n` at any time returns the block to IDLE and sets ptr = N_REQ−1. The divider shares `rst_n`. An in-flight operation is discarded with no response.
- **Reset values:** `req_ready`, `rsp_valid`, `rsp_quo`, `rsp_rem`, `rsp_dbz` and `busy` are all 0.

## Timing
- Cycle 0 is the cycle of the request handshake.
  - `start` is high in cycle 1.
  - The divider `done` is visible in cycle WIDTH+1 (b≠0) or in cycle 2 (b=0).
  - `rsp_valid[g]` rises in cycle WIDTH+2 (b≠0) or in cycle 3 (b=0).
- The next `req_ready` can be asserted in the cycle after the response handshake; there is no bypass.
- Minimum throughput is one division per WIDTH+3 cycles.
- Simultaneous `req_valid` on all ports: exactly one grant per IDLE visit.

## Structure
- **Package `div_share_pkg`:**
  - `state_t` enum (IDLE, LAUNCH, WAIT, RESP).
  - Function `rr_pick(req, ptr)` returning winner index and a found flag.
- **Sub-module:** exactly one, the `divu_int #(WIDTH)` instance. Its `valid` output is unused. Everything else stays flat in `div_share_arb`.

## Test plan
All scenarios use N_REQ = 4 and WIDTH = 16.
- **Single request:** req1 with num=100, den=7 → `rsp_valid[1]` high in cycle 18, quo=14, rem=2, dbz=0.
- **Divide by zero:** req2 with num=55, den=0 → `rsp_valid[2]` high in cycle 3, quo=16'hFFFF, rem=55, dbz=1.
- **Fairness:** all four `req_valid` held high from reset → grant order 0,1,2,3,0. With only req0 and req3 valid after requester 3's grant → next grant is 0, then 3.
- **Backpressure:** `rsp_ready[g]` held low for 10 cycles in RESP → response data stable, all `req_ready` = 0, no `start` pulse.
- **Reset mid-operation:** `rst_n` pulsed low in cycle 8 of a WAIT → all outputs 0 and `busy` = 0; a following request from req2 is granted and completes correctly (num=9, den=2 → quo=4, rem=1).
- **Edge operands:** num=65535, den=1 → quo=65535, rem=0. num=5, den=9 → quo=0, rem=5.
